// File: rtl/regs_arbiter_if.sv
// Bus bundle between core, debug port, arbiter and register file.
// slave = arbiter view; master = surrounding core/debug/regfile view.
interface regs_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [4:0]  core_rs1adr;
  logic [4:0]  core_rs2adr;
  logic [4:0]  core_rdadr;
  logic [31:0] core_wdata;
  logic        core_gnt;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_adr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        regwrite;
  logic [4:0]  rs1adr;
  logic [4:0]  rs2adr;
  logic [4:0]  rdadr;
  logic [31:0] rd;
  logic [31:0] rs1;
  logic [31:0] rs2;

  modport slave (
    input  core_req, core_we, core_rs1adr, core_rs2adr, core_rdadr, core_wdata,
    output core_gnt,
    input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output regwrite, rs1adr, rs2adr, rdadr, rd,
    input  rs1, rs2
  );

  modport master (
    output core_req, core_we, core_rs1adr, core_rs2adr, core_rdadr, core_wdata,
    input  core_gnt,
    output dbg_req, dbg_we, dbg_adr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  regwrite, rs1adr, rs2adr, rdadr, rd,
    output rs1, rs2
  );
endinterface

// File: rtl/regs_arbiter.sv
// Register-file port arbiter between core and debug access.
// Define REGS_ARB_STARVE_EN to force a debug grant after STARVE_LIMIT blocked cycles.
module regs_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           reset,
  regs_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

  state_t state, state_nxt;
  logic   dbg_gnt;
  logic   starve_hit;
  logic   rd_zero;

`ifdef REGS_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT));

  // Counts blocked debug cycles; saturates because the grant fires at the limit.
  always_ff @(posedge clk) begin
    if (reset)                                        starve_cnt <= '0;
    else if (dbg_gnt)                                 starve_cnt <= '0;
    else if (state == IDLE && bus.dbg_req && !starve_hit) starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    dbg_gnt      = 1'b0;
    bus.core_gnt = 1'b0;
    bus.regwrite = 1'b0;
    bus.rs1adr   = bus.core_rs1adr;
    bus.rs2adr   = bus.core_rs2adr;
    bus.rdadr    = bus.core_rdadr;
    bus.rd       = bus.core_wdata;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (bus.dbg_req && (!bus.core_req || starve_hit)) begin
            dbg_gnt = 1'b1;
            if (bus.dbg_we) begin
              bus.rdadr    = bus.dbg_adr;
              bus.rd       = bus.dbg_wdata;
              bus.regwrite = 1'b1;
              state_nxt    = ACK;
            end else begin
              bus.rs1adr = bus.dbg_adr;
              state_nxt  = RD_WAIT;
            end
          end else if (bus.core_req) begin
            bus.core_gnt = 1'b1;
            bus.regwrite = bus.core_we;
          end
        end
        RD_WAIT: state_nxt = ACK;
        ACK:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.dbg_ack   <= 1'b0;
      bus.dbg_rdata <= '0;
      rd_zero       <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.dbg_ack <= (state_nxt == ACK);
      if (dbg_gnt) rd_zero <= (bus.dbg_adr == 5'd0);
      // rs1 for the debug address arrives in RD_WAIT; x0 always reads as zero
      if (state == RD_WAIT) bus.dbg_rdata <= rd_zero ? 32'd0 : bus.rs1;
    end
  end
endmodule
